// File: rtl/key_pkg.sv
// Shared constants and types for the key debounce bank.
// The hold-state enum is only referenced when KEY_REPEAT_EN is defined.
package key_pkg;

   localparam int KEY_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      KEY_IDLE,
      KEY_HELD,
      KEY_REPEAT
   } key_hold_t;

   function automatic int key_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One active-low key channel: 2-FF synchronizer, debounce counter, press/release pulses.
// With KEY_REPEAT_EN defined and REPEAT_EN set, a hold FSM adds auto-repeat press pulses.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEB_CYCLES   = 1000,
   parameter int REPEAT_DELAY = 400000,
   parameter int REPEAT_RATE  = 100000,
   parameter bit REPEAT_EN    = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_level,
   output logic o_press,
   output logic o_release
);

   localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   logic [KEY_SYNC_STAGES-1:0] sync_q;
   logic [DEB_W-1:0]           deb_cnt_q, deb_cnt_d;
   logic                       level_q, level_d;
   logic                       press_q, release_q;
   logic                       raw_pressed, accept;
   logic                       press_edge, release_edge, repeat_pulse;

   if (DEB_CYCLES < 2) begin : g_bad_deb_cycles
      $error("key_debounce_ch: DEB_CYCLES must be at least 2");
   end
   if (REPEAT_EN && (REPEAT_DELAY < 1 || REPEAT_RATE < 1)) begin : g_bad_repeat
      $error("key_debounce_ch: repeat delay and rate must be at least 1");
   end

   assign raw_pressed = ~sync_q[KEY_SYNC_STAGES-1];

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      deb_cnt_d = '0;
      level_d   = level_q;
      accept    = 1'b0;
      if (raw_pressed != level_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            level_d = raw_pressed;
            accept  = 1'b1;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   assign press_edge   = accept & raw_pressed;
   assign release_edge = accept & ~raw_pressed;

`ifdef KEY_REPEAT_EN
   if (REPEAT_EN) begin : g_repeat
      localparam int                HOLD_W     = $clog2(key_max(REPEAT_DELAY, REPEAT_RATE) + 1);
      localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
      localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);

      key_hold_t         hold_q, hold_d;
      logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
      logic              rep_d;

      // Counters restart at each threshold, so they can never wrap while a key is held.
      always_comb begin
         hold_d     = hold_q;
         hold_cnt_d = hold_cnt_q;
         rep_d      = 1'b0;
         if (release_edge) begin
            hold_d     = KEY_IDLE;
            hold_cnt_d = '0;
         end else if (press_edge) begin
            hold_d     = KEY_HELD;
            hold_cnt_d = '0;
         end else begin
            case (hold_q)
               KEY_HELD: begin
                  if (hold_cnt_q == DELAY_LAST) begin
                     rep_d      = 1'b1;
                     hold_d     = KEY_REPEAT;
                     hold_cnt_d = '0;
                  end else begin
                     hold_cnt_d = hold_cnt_q + 1'b1;
                  end
               end
               KEY_REPEAT: begin
                  if (hold_cnt_q == RATE_LAST) begin
                     rep_d      = 1'b1;
                     hold_cnt_d = '0;
                  end else begin
                     hold_cnt_d = hold_cnt_q + 1'b1;
                  end
               end
               default: hold_cnt_d = '0;
            endcase
         end
      end

      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            hold_q     <= KEY_IDLE;
            hold_cnt_q <= '0;
         end else begin
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
         end
      end

      assign repeat_pulse = rep_d;
   end else begin : g_no_repeat
      assign repeat_pulse = 1'b0;
   end
`else
   assign repeat_pulse = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_q    <= '1;
         deb_cnt_q <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[KEY_SYNC_STAGES-2:0], i_key_n};
         deb_cnt_q <= deb_cnt_d;
         level_q   <= level_d;
         press_q   <= press_edge | repeat_pulse;
         release_q <= release_edge;
      end
   end

   assign o_level   = level_q;
   assign o_press   = press_q;
   assign o_release = release_q;

endmodule

// File: rtl/key_debounce_bank.sv
// Bank of N_KEYS independent debounced push-button channels.
// Auto-repeat on REPEAT_MASK channels exists only when KEY_REPEAT_EN is defined.
module key_debounce_bank #(
   parameter int                N_KEYS       = 4,
   parameter int                DEB_CYCLES   = 1000,
   parameter int                REPEAT_DELAY = 400000,
   parameter int                REPEAT_RATE  = 100000,
   parameter logic [N_KEYS-1:0] REPEAT_MASK  = 4'b0011
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [N_KEYS-1:0] i_key_n,
   output logic [N_KEYS-1:0] o_level,
   output logic [N_KEYS-1:0] o_press,
   output logic [N_KEYS-1:0] o_release
);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEB_CYCLES  (DEB_CYCLES),
         .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_RATE (REPEAT_RATE),
         .REPEAT_EN   (REPEAT_MASK[i])
      ) u_ch (
         .i_clk    (i_clk),
         .i_rst    (i_rst),
         .i_key_n  (i_key_n[i]),
         .o_level  (o_level[i]),
         .o_press  (o_press[i]),
         .o_release(o_release[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_bank.sv
// Table-driven bench for key_debounce_bank with DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// Each row: inputs applied, one clock edge, then {level,press,release} compared 1 time unit later.
module tb_key_debounce_bank;

   localparam int N_KEYS = 4;
   localparam int DEB    = 4;
   localparam int RDELAY = 10;
   localparam int RRATE  = 3;
`ifdef KEY_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N_KEYS-1:0] key_n = '1;
   logic [N_KEYS-1:0] level, press, rel;

   always #5 clk = ~clk;

   key_debounce_bank #(
      .N_KEYS      (N_KEYS),
      .DEB_CYCLES  (DEB),
      .REPEAT_DELAY(RDELAY),
      .REPEAT_RATE (RRATE),
      .REPEAT_MASK (4'b0011)
   ) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_key_n  (key_n),
      .o_level  (level),
      .o_press  (press),
      .o_release(rel)
   );

   typedef struct {
      string      phase;
      logic       rst;
      logic [3:0] key_n;
      logic [3:0] level;
      logic [3:0] press;
      logic [3:0] rel;
   } vec_t;

   vec_t vq[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: level/press/release got %b_%b_%b required %b_%b_%b", name,
                  act[11:8], act[7:4], act[3:0], exp[11:8], exp[7:4], exp[3:0]);
      end
   endtask

   task automatic add(input string phase, input logic r, input logic [3:0] k,
                      input logic [3:0] l, input logic [3:0] p, input logic [3:0] rl);
      vec_t v;
      v.phase = phase; v.rst = r; v.key_n = k; v.level = l; v.press = p; v.rel = rl;
      vq.push_back(v);
   endtask

   initial begin
      int row;
      logic b0, b1, b2;

      // Reset with keys released, then idle.
      for (int r = 0; r < 3; r++) add("reset", 1'b1, 4'b1111, 4'b0, 4'b0, 4'b0);
      for (int r = 0; r < 3; r++) add("idle", 1'b0, 4'b1111, 4'b0, 4'b0, 4'b0);

      // Clean key0 press (level at row 5) and release (pulse at row 25).
      for (int r = 0; r < 32; r++) begin
         b0 = (r == 5) || (REP && r >= 15 && r < 25 && (r - 15) % 3 == 0);
         add("key0_clean", 1'b0, (r < 20) ? 4'b1110 : 4'b1111,
             {3'b000, (r >= 5 && r < 25)}, {3'b000, b0}, {3'b000, (r == 25)});
      end

      // Key1 3-cycle glitch, then long key1 press; keys 2,3 pressed together.
      // Key1 release lands on a would-be repeat cycle (row 31).
      for (int r = 0; r < 34; r++) begin
         logic [3:0] k;
         k = 4'b1111;
         if (r < 3 || (r >= 10 && r < 26)) k[1] = 1'b0;
         if (r >= 12 && r < 26) k[3:2] = 2'b00;
         b1 = (r == 15) || (REP && r >= 25 && r < 31 && (r - 25) % 3 == 0);
         add("glitch_multi", 1'b0, k,
             {{2{r >= 17 && r < 31}}, (r >= 15 && r < 31), 1'b0},
             {{2{r == 17}}, b1, 1'b0},
             (r == 31) ? 4'b1110 : 4'b0000);
      end

      // Long hold on key0 (repeat-enabled) and key2 (masked).
      for (int r = 0; r < 45; r++) begin
         b0 = (r == 5) || (REP && r >= 15 && r < 41 && (r - 15) % 3 == 0);
         b2 = (r == 5);
         add("hold", 1'b0, (r < 36) ? 4'b1010 : 4'b1111,
             (r >= 5 && r < 41) ? 4'b0101 : 4'b0000,
             {1'b0, b2, 1'b0, b0}, (r == 41) ? 4'b0101 : 4'b0000);
      end

      // Reset while key0 is mid-debounce (count=2), key still low after reset release.
      for (int r = 0; r < 4; r++) add("rst_mid", 1'b0, 4'b1110, 4'b0, 4'b0, 4'b0);
      add("rst_mid", 1'b1, 4'b1110, 4'b0, 4'b0, 4'b0);
      add("rst_mid", 1'b1, 4'b1110, 4'b0, 4'b0, 4'b0);
      for (int r = 0; r < 5; r++) add("rst_after", 1'b0, 4'b1110, 4'b0, 4'b0, 4'b0);
      add("rst_after", 1'b0, 4'b1110, 4'b0001, 4'b0001, 4'b0);
      add("rst_after", 1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0);
      for (int r = 0; r < 5; r++) add("rst_rel", 1'b0, 4'b1111, 4'b0001, 4'b0, 4'b0);
      add("rst_rel", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001);
      add("rst_rel", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      add("rst_rel", 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

      row = 0;
      foreach (vq[j]) begin
         rst   = vq[j].rst;
         key_n = vq[j].key_n;
         @(posedge clk);
         #1;
         check($sformatf("%s_row%0d", vq[j].phase, row),
               {level, press, rel}, {vq[j].level, vq[j].press, vq[j].rel});
         row = (j + 1 < vq.size() && vq[j + 1].phase == vq[j].phase) ? row + 1 : 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
